noc_out_port_arbiter: RTL and testbench

- Per-output-port scheduler for one 4x4 mesh router.
- Shares a single 16-bit output link between N input-port requesters using round-robin arbitration, with packet-level locking from head flit to tail flit.
- Tracks downstream buffer space with a credit counter and never sends without a credit.
- Feeds the router's data_o/valid_o pair for one direction and consumes that direction's credit_i.

---
 rtl/noc_out_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_noc_out_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_port_arbiter.sv
// ---------------------------------------------------------------------------
// noc_out_port_arbiter
//
// Output-port scheduler for one direction of a 4x4 mesh router. N input-port
// requesters share one FLIT_W-bit output link. Requesters are picked
// round-robin. A head flit locks the link to its owner until the matching
// tail. A credit counter tracks free downstream buffer slots, and no flit is
// sent without a credit.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   req_valid_i  [N]          requester i has a flit at its FIFO head
//   req_data_i   [N*FLIT_W]   head flits, requester i at [i*FLIT_W +: FLIT_W]
//   req_pop_o    [N]          combinational one-hot pop of the selected flit
//   valid_o                   registered, data_o carries a flit this cycle
//   data_o       [FLIT_W]     registered output flit
//   credit_i                  one-cycle pulse, downstream freed one slot
//   grant_o      [N]          one-hot packet owner while locked, else 0
//   busy_o                    1 while a packet holds the lock
//   err_o                     sticky credit-overflow error
// ---------------------------------------------------------------------------
module noc_out_port_arbiter #(
  parameter int N         = 4,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_valid_i,
  input  logic [N*FLIT_W-1:0] req_data_i,
  output logic [N-1:0]        req_pop_o,
  output logic                valid_o,
  output logic [FLIT_W-1:0]   data_o,
  input  logic                credit_i,
  output logic [N-1:0]        grant_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(N);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);
  localparam logic [1:0]       HEAD    = 2'b10;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;

  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_found;
  logic [PTR_W-1:0] send_idx;
  logic             send;
  logic [FLIT_W-1:0] send_flit;
  logic [1:0]       send_type;
  logic [N-1:0]     send_onehot;

  // Round-robin search starting just after the last winner, wrapping mod N.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N);
      if (!rr_found && req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // While locked only the owner may send; cnt is registered, so a credit
  // arriving this cycle cannot enable a send until the next one.
  always_comb begin
    send_idx    = (state == LOCKED) ? owner : rr_idx;
    send        = (cnt != '0) &&
                  ((state == LOCKED) ? req_valid_i[owner] : rr_found);
    send_flit   = req_data_i[int'(send_idx)*FLIT_W +: FLIT_W];
    send_type   = send_flit[FLIT_W-1 -: 2];
    send_onehot = '0;
    send_onehot[send_idx] = 1'b1;
  end

  // Pops are suppressed while reset is held, even though the reset state
  // would otherwise allow a send.
  always_comb begin
    req_pop_o = '0;
    if (reset && send) begin
      req_pop_o = send_onehot;
    end
  end

  assign busy_o = (state == LOCKED);

  // Output register and packet-lock state. In IDLE only a head flit takes
  // the lock; body and tail flits there go out as singles. In LOCKED a tail
  // or single (type bit 0 set) releases the lock and hands priority on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      state   <= IDLE;
      owner   <= '0;
      grant_o <= '0;
      rr_ptr  <= PTR_W'(N - 1);
    end else begin
      valid_o <= send;
      if (send) begin
        data_o <= send_flit;
        if (state == IDLE) begin
          rr_ptr <= send_idx;
          if (send_type == HEAD) begin
            state   <= LOCKED;
            owner   <= send_idx;
            grant_o <= send_onehot;
          end
        end else if (send_type[0]) begin
          state   <= IDLE;
          rr_ptr  <= owner;
          grant_o <= '0;
        end
      end
    end
  end

  // Credit counter. A send and a credit in the same cycle cancel out. A
  // credit with the counter already full saturates and raises err_o.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= CNT_MAX;
      err_o <= 1'b0;
    end else begin
      case ({send, credit_i})
        2'b10: cnt <= cnt - CNT_W'(1);
        2'b01: begin
          if (cnt == CNT_MAX) begin
            err_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_out_port_arbiter
//
// Self-checking bench for noc_out_port_arbiter. Each requester is a queue of
// flits. A reference model predicts pops and outputs every cycle from the
// scheduling rules: round-robin pick, packet lock, and credits. Directed
// scenarios add literal expectations, then a randomized packet phase runs.
// ---------------------------------------------------------------------------
module tb_noc_out_port_arbiter;

  localparam int N         = 4;
  localparam int BUF_DEPTH = 4;
  localparam int FLIT_W    = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid_i = '0;
  logic [N*FLIT_W-1:0] req_data_i = '0;
  logic [N-1:0]        req_pop_o;
  logic                valid_o;
  logic [FLIT_W-1:0]   data_o;
  logic                credit_i = 1'b0;
  logic [N-1:0]        grant_o;
  logic                busy_o;
  logic                err_o;

  noc_out_port_arbiter #(.N(N), .BUF_DEPTH(BUF_DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_pop_o(req_pop_o), .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [FLIT_W-1:0] fifo [N][$];
  logic [N-1:0]      mask = '0;

  int checks = 0;
  int errors = 0;

  int                m_cnt;
  int                m_rr;
  int                m_owner;
  bit                m_locked;
  bit                m_err;
  bit                m_valid;
  logic [FLIT_W-1:0] m_data;

  logic [N-1:0]      popLog[$];
  bit                validLog[$];
  logic [FLIT_W-1:0] validData[$];
  logic [N-1:0]      grantLog[$];
  bit                errLog[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit offering(input int i);
    return (fifo[i].size() != 0) && !mask[i];
  endfunction

  task automatic clearLogs();
    popLog.delete(); validLog.delete(); validData.delete();
    grantLog.delete(); errLog.delete();
  endtask

  // Assert reset at a falling edge, check the outputs clear at once (even
  // with every requester offering a flit), then release on a later falling edge.
  task automatic resetDut();
    req_valid_i = '1;
    req_data_i  = {N{16'hC0FF}};
    credit_i    = 1'b0;
    reset       = 1'b0;
    #1;
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset data_o", 32'(data_o), 32'd0);
    checkOutput("reset grant_o", 32'(grant_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset err_o", 32'(err_o), 32'd0);
    checkOutput("reset req_pop_o", 32'(req_pop_o), 32'd0);
    m_cnt = BUF_DEPTH; m_rr = N - 1; m_owner = 0;
    m_locked = 0; m_err = 0; m_valid = 0; m_data = '0;
    for (int i = 0; i < N; i++) fifo[i].delete();
    mask = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearLogs();
  endtask

  // One clock cycle: drive inputs, predict, compare, then advance the model.
  task automatic applyStimulus(input bit credit);
    int                idx;
    bit                sendExp;
    logic [N-1:0]      expPop;
    logic [N-1:0]      expGrant;
    logic [FLIT_W-1:0] flit;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = offering(i);
      req_data_i[i*FLIT_W +: FLIT_W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
    credit_i = credit;
    #1;
    sendExp = 0;
    idx     = 0;
    if (m_cnt > 0) begin
      if (!m_locked) begin
        for (int k = 1; k <= N; k++) begin
          if (!sendExp && offering((m_rr + k) % N)) begin
            sendExp = 1;
            idx     = (m_rr + k) % N;
          end
        end
      end else if (offering(m_owner)) begin
        sendExp = 1;
        idx     = m_owner;
      end
    end
    expPop = '0;
    if (sendExp) expPop[idx] = 1'b1;
    expGrant = '0;
    if (m_locked) expGrant[m_owner] = 1'b1;
    checkOutput("req_pop_o", 32'(req_pop_o), 32'(expPop));
    checkOutput("valid_o", 32'(valid_o), 32'(m_valid));
    if (m_valid) checkOutput("data_o", 32'(data_o), 32'(m_data));
    checkOutput("grant_o", 32'(grant_o), 32'(expGrant));
    checkOutput("busy_o", 32'(busy_o), 32'(m_locked));
    checkOutput("err_o", 32'(err_o), 32'(m_err));
    popLog.push_back(req_pop_o);
    validLog.push_back(valid_o);
    if (valid_o) validData.push_back(data_o);
    grantLog.push_back(grant_o);
    errLog.push_back(err_o);
    @(posedge clk);
    m_valid = sendExp;
    if (sendExp) begin
      flit   = fifo[idx].pop_front();
      m_data = flit;
      if (!m_locked) begin
        m_rr = idx;
        if (flit[15:14] == 2'b10) begin
          m_locked = 1;
          m_owner  = idx;
        end
      end else if (flit[14]) begin
        m_locked = 0;
        m_rr     = m_owner;
      end
    end
    if (credit && !sendExp) begin
      if (m_cnt == BUF_DEPTH) m_err = 1;
      else m_cnt++;
    end else if (sendExp && !credit) begin
      m_cnt--;
    end
    @(negedge clk);
  endtask

  task automatic pushPacket(input int i);
    int                len;
    logic [1:0]        ty;
    logic [1:0]        loneTypes [3];
    logic [FLIT_W-1:0] f;
    loneTypes = '{2'b11, 2'b00, 2'b01};
    len = $urandom_range(1, 4);
    for (int j = 0; j < len; j++) begin
      if (len == 1) ty = loneTypes[$urandom_range(0, 2)];
      else if (j == 0) ty = 2'b10;
      else if (j == len - 1) ty = 2'b01;
      else ty = 2'b00;
      f = {ty, 2'(i), 12'($urandom)};
      fifo[i].push_back(f);
    end
  endtask

  initial begin
    logic [8:0]        pBits9;
    logic [8:0]        vBits9;
    logic [9:0]        pBits10;
    logic [6:0]        vBits7;
    logic [FLIT_W-1:0] expSeq[$];
    int                pops;

    @(negedge clk);
    resetDut();

    // Credit exhaustion: six singles from req0, one credit in cycle 6.
    for (int k = 0; k < 6; k++) fifo[0].push_back(16'hC0A0 + 16'(k));
    for (int c = 0; c < 9; c++) applyStimulus(c == 6);
    for (int c = 0; c < 9; c++) begin
      pBits9[c] = popLog[c][0];
      vBits9[c] = validLog[c];
    end
    checkOutput("exhaust pop pattern", 32'(pBits9), 32'h08F);
    checkOutput("exhaust valid pattern", 32'(vBits9), 32'h11E);

    // Round robin across four single-flit requesters, credit every cycle.
    resetDut();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) fifo[i].push_back(16'hC000 + 16'(i));
    for (int c = 0; c < 14; c++) applyStimulus(c >= 1);
    checkOutput("rr flits delivered", 32'(validData.size()), 32'd12);
    expSeq = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC000};
    for (int j = 0; j < 5; j++)
      checkOutput($sformatf("rr data %0d", j), 32'(validData[j]), 32'(expSeq[j]));

    // Packet lock: req1 head/body/tail while req2 waits with a single.
    resetDut();
    fifo[1].push_back(16'h8011); fifo[1].push_back(16'h0012); fifo[1].push_back(16'h4013);
    fifo[2].push_back(16'hC020);
    for (int c = 0; c < 6; c++) applyStimulus(1'b0);
    expSeq = '{16'h8011, 16'h0012, 16'h4013, 16'hC020};
    checkOutput("lock flits delivered", 32'(validData.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("lock data %0d", j), 32'(validData[j]), 32'(expSeq[j]));
    checkOutput("lock grant c1", 32'(grantLog[1]), 32'h2);
    checkOutput("lock grant c2", 32'(grantLog[2]), 32'h2);
    checkOutput("lock pop c2", 32'(popLog[2]), 32'h2);
    checkOutput("lock pop c3", 32'(popLog[3]), 32'h4);

    // Owner bubble: req1 drops valid in cycles 2-3 while req3 waits.
    resetDut();
    fifo[1].push_back(16'h8011); fifo[1].push_back(16'h0012);
    fifo[1].push_back(16'h0013); fifo[1].push_back(16'h4014);
    fifo[3].push_back(16'hC030);
    for (int c = 0; c < 9; c++) begin
      mask = (c == 2 || c == 3) ? 4'b0010 : 4'b0000;
      applyStimulus(c == 2);
    end
    mask = '0;
    for (int c = 1; c < 8; c++) vBits7[c-1] = validLog[c];
    checkOutput("bubble valid pattern", 32'(vBits7), 32'h73);
    checkOutput("bubble pop c2", 32'(popLog[2]), 32'h0);
    checkOutput("bubble pop c3", 32'(popLog[3]), 32'h0);
    checkOutput("bubble pop c6", 32'(popLog[6]), 32'h8);
    expSeq = '{16'h8011, 16'h0012, 16'h0013, 16'h4014, 16'hC030};
    for (int j = 0; j < 5; j++)
      checkOutput($sformatf("bubble data %0d", j), 32'(validData[j]), 32'(expSeq[j]));

    // Credit boundary: send+credit at cnt=1, then overflow once full.
    resetDut();
    for (int k = 0; k < 6; k++) fifo[0].push_back(16'hC100 + 16'(k));
    for (int c = 0; c < 16; c++) applyStimulus(c == 3 || (c >= 8 && c <= 13));
    for (int c = 0; c < 10; c++) pBits10[c] = popLog[c][0];
    checkOutput("boundary pop pattern", 32'(pBits10), 32'h21F);
    checkOutput("boundary err c13", 32'(errLog[13]), 32'd0);
    checkOutput("boundary err c14", 32'(errLog[14]), 32'd1);
    checkOutput("boundary err c15", 32'(errLog[15]), 32'd1);
    for (int k = 0; k < 5; k++) fifo[0].push_back(16'hC200 + 16'(k));
    clearLogs();
    for (int c = 0; c < 6; c++) applyStimulus(1'b0);
    pops = 0;
    foreach (popLog[c]) pops += int'(popLog[c][0]);
    checkOutput("full counter pops", 32'(pops), 32'd4);
    checkOutput("err still set", 32'(errLog[5]), 32'd1);

    // Reset one cycle after a req2 head goes out.
    resetDut();
    fifo[2].push_back(16'h8021); fifo[2].push_back(16'h0022); fifo[2].push_back(16'h4023);
    applyStimulus(1'b0);
    checkOutput("pre-reset busy_o", 32'(busy_o), 32'd1);
    checkOutput("pre-reset valid_o", 32'(valid_o), 32'd1);
    resetDut();
    fifo[0].push_back(16'hC001);
    fifo[2].push_back(16'h8024); fifo[2].push_back(16'h4025);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0);
    checkOutput("post-reset first pop", 32'(popLog[0]), 32'h1);
    checkOutput("post-reset second pop", 32'(popLog[1]), 32'h4);

    // Randomized packets, valid drops and credits against the model.
    resetDut();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (fifo[i].size() < 2 && $urandom_range(0, 3) == 0) pushPacket(i);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus((m_cnt < BUF_DEPTH && $urandom_range(0, 1) == 1) ||
                    $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
